// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, funct3
// encodings, mstatus field positions and write masks.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_f3_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
    localparam logic [63:0] MTVEC_WMASK   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] MEPC_WMASK    = 64'hFFFF_FFFF_FFFF_FFFC;
endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter split into two XLEN halves; a write to
// either half replaces it and holds off the increment for that cycle.
module csr_counter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi
);
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] cur, nxt;

    // Work in a 2*XLEN view so the high half exists even when CNT_W < 2*XLEN.
    assign cur = (2*XLEN)'(cnt);
    assign lo  = cur[XLEN-1:0];
    assign hi  = cur[2*XLEN-1:XLEN];

    always_comb begin
        nxt = cur;
        if (wr_lo)
            nxt[XLEN-1:0] = wdata;
        else if (wr_hi)
            nxt[2*XLEN-1:XLEN] = wdata;
        else if (inc)
            nxt = cur + {{(2*XLEN-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= nxt[CNT_W-1:0];
    end
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read/decode, masked writes,
// cycle/instret counters, and trap-entry / mret updates of mstatus.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      CSRControl,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd,
    output logic            illegal,
    input  logic            retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global
);
    logic [11:0]     addr;
    logic [4:0]      rs1f;
    logic [2:0]      f3;
    logic            en, hit, bad_f3, intent, ro, we;
    logic [XLEN-1:0] src, nv, old, mstatus_rd;
    logic            mie_b, mpie_b;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic            unused_instr;

    assign addr = instr[31:20];
    assign rs1f = instr[19:15];
    assign f3   = CSRControl[2:0];
    assign en   = CSRControl[3];
    assign ro   = (addr[11:10] == 2'b11);
    assign unused_instr = ^instr[14:0];

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]      = mie_b;
        mstatus_rd[MSTATUS_MPIE]     = mpie_b;
        mstatus_rd[MSTATUS_MPP +: 2] = 2'b11;
    end

    always_comb begin
        hit = 1'b1;
        old = '0;
        case (addr)
            CSR_MSTATUS:                 old = mstatus_rd;
            CSR_MIE:                     old = mie_q;
            CSR_MTVEC:                   old = mtvec_q;
            CSR_MSCRATCH:                old = mscratch_q;
            CSR_MEPC:                    old = mepc_q;
            CSR_MCAUSE:                  old = mcause_q;
            CSR_MTVAL:                   old = mtval_q;
            CSR_MIP:                     old = '0;
            CSR_MCYCLE,   CSR_CYCLE:     old = cyc_lo;
            CSR_MCYCLEH,  CSR_CYCLEH:    old = cyc_hi;
            CSR_MINSTRET, CSR_INSTRET:   old = ins_lo;
            CSR_MINSTRETH, CSR_INSTRETH: old = ins_hi;
            CSR_MHARTID:                 old = HART_ID;
            default:                     hit = 1'b0;
        endcase
    end

    assign src = f3[2] ? {{(XLEN-5){1'b0}}, rs1f} : wd;

    // Set/clear with rs1 field zero is a pure read, so it never trips read-only checks.
    always_comb begin
        nv     = src;
        intent = 1'b0;
        bad_f3 = 1'b0;
        case (f3)
            CSRRW, CSRRWI: intent = 1'b1;
            CSRRS, CSRRSI: begin nv = old | src;  intent = (rs1f != 5'd0); end
            CSRRC, CSRRCI: begin nv = old & ~src; intent = (rs1f != 5'd0); end
            default:       bad_f3 = 1'b1;
        endcase
    end

    assign illegal = en & (~hit | bad_f3 | (ro & intent));
    assign we      = en & ~illegal & intent & ~trap_valid;
    assign rd      = old;

    assign mtvec_o    = mtvec_q;
    assign mepc_o     = mepc_q;
    assign mie_global = mie_b;

    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mcycle (
        .clk(clk), .reset(reset), .inc(1'b1),
        .wr_lo(we && addr == CSR_MCYCLE), .wr_hi(we && addr == CSR_MCYCLEH),
        .wdata(nv), .lo(cyc_lo), .hi(cyc_hi)
    );

    csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_minstret (
        .clk(clk), .reset(reset), .inc(retire),
        .wr_lo(we && addr == CSR_MINSTRET), .wr_hi(we && addr == CSR_MINSTRETH),
        .wdata(nv), .lo(ins_lo), .hi(ins_hi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_b      <= 1'b0;
            mpie_b     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & XLEN'(MEPC_WMASK);
            mcause_q <= trap_cause;
            mtval_q  <= trap_val;
            mpie_b   <= mie_b;
            mie_b    <= 1'b0;
        end else begin
            if (we) begin
                case (addr)
                    CSR_MSTATUS: begin
                        mie_b  <= nv[MSTATUS_MIE];
                        mpie_b <= nv[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= nv;
                    CSR_MTVEC:    mtvec_q    <= nv & XLEN'(MTVEC_WMASK);
                    CSR_MSCRATCH: mscratch_q <= nv;
                    CSR_MEPC:     mepc_q     <= nv & XLEN'(MEPC_WMASK);
                    CSR_MCAUSE:   mcause_q   <= nv;
                    CSR_MTVAL:    mtval_q    <= nv;
                    default: ;
                endcase
            end
            // mret lands after any same-cycle mstatus write, so it wins.
            if (mret) begin
                mie_b  <= mpie_b;
                mpie_b <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the architected CSR state.
module tb_csr_unit;
    localparam logic [31:0] MTV = 32'h0000_0400;
    localparam logic [31:0] HID = 32'h0000_0003;
    localparam logic [3:0] RW = 4'b1001, RS = 4'b1010, RC = 4'b1011;
    localparam logic [3:0] RWI = 4'b1101, RSI = 4'b1110, RCI = 4'b1111;

    logic        clk, reset, illegal, retire, trap_valid, mret, mie_global;
    logic [3:0]  CSRControl;
    logic [31:0] instr, wd, rd, trap_cause, trap_pc, trap_val, mtvec_o, mepc_o;
    int n_tests = 0, n_fail = 0;

    csr_unit #(.XLEN(32), .CNT_W(64), .MTVEC_RESET(MTV), .HART_ID(HID)) dut (
        .clk(clk), .reset(reset), .CSRControl(CSRControl), .instr(instr), .wd(wd),
        .rd(rd), .illegal(illegal), .retire(retire), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val), .mret(mret),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_global(mie_global)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architected state held as plain variables and 64-bit counters.
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    logic        e_hit, e_intent, e_ill, e_we;
    logic [31:0] e_rd, e_src, e_nv;
    logic [11:0] m_addr;

    assign m_addr = instr[31:20];

    always_comb begin
        e_hit = 1'b1;
        e_rd  = 32'h0;
        case (m_addr)
            12'h300: e_rd = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: e_rd = m_mie_r;
            12'h305: e_rd = m_mtvec;
            12'h340: e_rd = m_mscratch;
            12'h341: e_rd = m_mepc;
            12'h342: e_rd = m_mcause;
            12'h343: e_rd = m_mtval;
            12'h344: e_rd = 32'h0;
            12'hB00, 12'hC00: e_rd = m_cyc[31:0];
            12'hB80, 12'hC80: e_rd = m_cyc[63:32];
            12'hB02, 12'hC02: e_rd = m_ins[31:0];
            12'hB82, 12'hC82: e_rd = m_ins[63:32];
            12'hF14: e_rd = HID;
            default: e_hit = 1'b0;
        endcase
        e_src    = CSRControl[2] ? {27'h0, instr[19:15]} : wd;
        e_intent = (CSRControl[1:0] == 2'b01) || (instr[19:15] != 5'd0);
        case (CSRControl[1:0])
            2'b01:   e_nv = e_src;
            2'b10:   e_nv = e_rd | e_src;
            2'b11:   e_nv = e_rd & ~e_src;
            default: e_nv = 32'h0;
        endcase
        e_ill = CSRControl[3] && (!e_hit || CSRControl[1:0] == 2'b00 ||
                                  (m_addr >= 12'hC00 && e_intent));
        e_we  = CSRControl[3] && !e_ill && e_intent && !trap_valid;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mie <= 0; m_mpie <= 0; m_mie_r <= 0; m_mtvec <= MTV; m_mscratch <= 0;
            m_mepc <= 0; m_mcause <= 0; m_mtval <= 0; m_cyc <= 0; m_ins <= 0;
        end else begin
            m_cyc <= m_cyc + 64'd1;
            if (retire) m_ins <= m_ins + 64'd1;
            if (trap_valid) begin
                m_mepc <= {trap_pc[31:2], 2'b00}; m_mcause <= trap_cause; m_mtval <= trap_val;
                m_mpie <= m_mie; m_mie <= 1'b0;
            end else begin
                if (e_we) begin
                    case (m_addr)
                        12'h300: begin m_mie <= e_nv[3]; m_mpie <= e_nv[7]; end
                        12'h304: m_mie_r <= e_nv;
                        12'h305: m_mtvec <= {e_nv[31:2], 2'b00};
                        12'h340: m_mscratch <= e_nv;
                        12'h341: m_mepc <= {e_nv[31:2], 2'b00};
                        12'h342: m_mcause <= e_nv;
                        12'h343: m_mtval <= e_nv;
                        12'hB00: m_cyc <= {m_cyc[63:32], e_nv};
                        12'hB80: m_cyc <= {e_nv, m_cyc[31:0]};
                        12'hB02: m_ins <= {m_ins[63:32], e_nv};
                        12'hB82: m_ins <= {e_nv, m_ins[31:0]};
                        default: ;
                    endcase
                end
                if (mret) begin m_mie <= m_mpie; m_mpie <= 1'b1; end
            end
        end
    end

    task automatic setop(input logic [3:0] ctl, input logic [11:0] a,
                         input logic [4:0] r1, input logic [31:0] w);
        CSRControl = ctl;
        instr      = {a, r1, ctl[2:0], 5'd1, 7'h73};
        wd         = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; retire = 0; trap_valid = 0; mret = 0;
        trap_cause = 0; trap_pc = 0; trap_val = 0;
        setop(RS, 12'h305, 5'd0, 32'h0); #1;
        n_tests++; if (rd !== MTV) begin n_fail++; $display("FAIL reset_mtvec rd=%h exp=%h", rd, MTV); end
        n_tests++; if (mtvec_o !== MTV) begin n_fail++; $display("FAIL reset_mtvec_o got=%h exp=%h", mtvec_o, MTV); end
        setop(RS, 12'h300, 5'd0, 32'h0); #1;
        n_tests++; if (rd !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus rd=%h exp=00001800", rd); end
        n_tests++; if (mie_global !== 1'b0) begin n_fail++; $display("FAIL reset_mie got=%b exp=0", mie_global); end
        n_tests++; if (mepc_o !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got=%h exp=0", mepc_o); end
        @(negedge clk); reset = 1'b0;
        tick();
        setop(RS, 12'hC00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL reset_cycle rd=%h exp=1", rd); end
        tick();
    endtask

    task automatic test_scratch();
        setop(RW, 12'h340, 5'd1, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL scratch_old rd=%h exp=0", rd); end
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL scratch_ill got=%b exp=0", illegal); end
        tick();
        setop(RS, 12'h340, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL scratch_new rd=%h exp=deadbeef", rd); end
        tick();
        setop(4'b1000, 12'h340, 5'd1, 32'h1);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL f3_000_ill got=%b exp=1", illegal); end
        tick();
        setop(4'b1100, 12'h340, 5'd1, 32'h1);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL f3_100_ill got=%b exp=1", illegal); end
        tick();
        setop(RS, 12'h340, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL f3_bad_nowrite rd=%h exp=deadbeef", rd); end
        tick();
    endtask

    task automatic test_mstatus();
        setop(RS, 12'h300, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL csrrs_x0_ill got=%b exp=0", illegal); end
        tick();
        setop(RSI, 12'h300, 5'd8, 32'h0);
        @(negedge clk);
        n_tests++; if (mie_global !== 1'b0) begin n_fail++; $display("FAIL csrrs_x0_nowrite mie=%b exp=0", mie_global); end
        tick();
        setop(RS, 12'h300, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (mie_global !== 1'b1) begin n_fail++; $display("FAIL csrrsi_mie got=%b exp=1", mie_global); end
        n_tests++; if (rd !== 32'h1808) begin n_fail++; $display("FAIL csrrsi_rd rd=%h exp=00001808", rd); end
        tick();
        setop(RW, 12'h300, 5'd1, 32'hFFFF_FFFF);
        tick();
        setop(RS, 12'h300, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h1888) begin n_fail++; $display("FAIL mstatus_mask rd=%h exp=00001888", rd); end
        tick();
        setop(RCI, 12'h300, 5'd8, 32'h0);
        tick();
        setop(RC, 12'h300, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h1880) begin n_fail++; $display("FAIL csrrci_rd rd=%h exp=00001880", rd); end
        tick();
        setop(RW, 12'h305, 5'd1, 32'h1234_5677);
        tick();
        setop(4'b0000, 12'h000, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (mtvec_o !== 32'h1234_5674) begin n_fail++; $display("FAIL mtvec_mask got=%h exp=12345674", mtvec_o); end
        tick();
    endtask

    task automatic test_readonly();
        setop(RW, 12'hC00, 5'd1, 32'h1234);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ro_write_ill got=%b exp=1", illegal); end
        tick();
        setop(RS, 12'hC00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ro_read_ill got=%b exp=0", illegal); end
        n_tests++; if (rd !== e_rd) begin n_fail++; $display("FAIL ro_cycle rd=%h exp=%h", rd, e_rd); end
        tick();
        setop(RC, 12'hF14, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b0 || rd !== HID) begin n_fail++; $display("FAIL hartid ill=%b rd=%h exp 0/%h", illegal, rd, HID); end
        tick();
        setop(RWI, 12'hF14, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL hartid_rwi_ill got=%b exp=1", illegal); end
        tick();
        setop(RS, 12'h301, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (illegal !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unimpl ill=%b rd=%h exp 1/0", illegal, rd); end
        tick();
    endtask

    task automatic preload_lo_ff();
        setop(RW, 12'hB00, 5'd1, 32'hFFFF_FFFF);
        tick();
        setop(RW, 12'hB80, 5'd1, 32'h0);
        tick();
    endtask

    task automatic test_counters();
        preload_lo_ff();
        setop(RS, 12'hB00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL preload_lo rd=%h exp=ffffffff", rd); end
        tick();
        setop(RS, 12'hB80, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL carry_hi rd=%h exp=1", rd); end
        tick();
        preload_lo_ff();
        setop(RS, 12'hB80, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL preload_hi rd=%h exp=0", rd); end
        tick();
        setop(RS, 12'hB00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL carry_lo rd=%h exp=0", rd); end
        tick();
        preload_lo_ff();
        setop(RW, 12'hB00, 5'd1, 32'h55);
        tick();
        setop(RS, 12'hB80, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_write_hi rd=%h exp=0", rd); end
        tick();
        setop(RS, 12'hB00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h56) begin n_fail++; $display("FAIL wrap_write_lo rd=%h exp=56", rd); end
        tick();
        retire = 1'b1;
        setop(RW, 12'hB02, 5'd1, 32'h7);
        tick();
        setop(4'b0000, 12'h000, 5'd0, 32'h0);
        tick();
        retire = 1'b0;
        setop(RS, 12'hC02, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL instret_inc rd=%h exp=8", rd); end
        tick();
        @(negedge clk);
        n_tests++; if (rd !== 32'h8) begin n_fail++; $display("FAIL instret_hold rd=%h exp=8", rd); end
        tick();
    endtask

    task automatic test_trap();
        setop(RSI, 12'h300, 5'd8, 32'h0);
        tick();
        trap_valid = 1'b1; trap_pc = 32'h103; trap_cause = 32'hB; trap_val = 32'hCAFE; mret = 1'b1;
        setop(RW, 12'h342, 5'd1, 32'h77);
        tick();
        trap_valid = 1'b0; mret = 1'b0;
        setop(RS, 12'h342, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'hB) begin n_fail++; $display("FAIL trap_mcause rd=%h exp=b", rd); end
        n_tests++; if (mepc_o !== 32'h100) begin n_fail++; $display("FAIL trap_mepc got=%h exp=100", mepc_o); end
        n_tests++; if (mie_global !== 1'b0) begin n_fail++; $display("FAIL trap_mie got=%b exp=0", mie_global); end
        tick();
        setop(RS, 12'h300, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus rd=%h exp=00001880", rd); end
        tick();
        setop(RS, 12'h343, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'hCAFE) begin n_fail++; $display("FAIL trap_mtval rd=%h exp=cafe", rd); end
        tick();
        mret = 1'b1;
        setop(4'b0000, 12'h000, 5'd0, 32'h0);
        tick();
        mret = 1'b0;
        setop(RS, 12'h300, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (mie_global !== 1'b1 || rd !== 32'h1888) begin n_fail++; $display("FAIL mret mie=%b rd=%h exp 1/00001888", mie_global, rd); end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] al [0:19];
        al = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
               12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
               12'hF14, 12'h301, 12'h7C0, 12'h000};
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ctl;
            logic [4:0] r1;
            ctl[3]   = ($urandom_range(0, 3) != 0);
            ctl[2:0] = 3'($urandom_range(0, 7));
            r1       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            setop(ctl, al[$urandom_range(0, 19)], r1, $urandom);
            retire     = 1'($urandom);
            trap_valid = ($urandom_range(0, 15) == 0);
            mret       = ($urandom_range(0, 15) == 0);
            trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
            @(negedge clk);
            n_tests++; if (rd !== e_rd) begin n_fail++; $display("FAIL rand_rd i=%0d addr=%h rd=%h exp=%h", i, m_addr, rd, e_rd); end
            n_tests++; if (illegal !== e_ill) begin n_fail++; $display("FAIL rand_ill i=%0d got=%b exp=%b", i, illegal, e_ill); end
            n_tests++; if (mie_global !== m_mie) begin n_fail++; $display("FAIL rand_mie i=%0d got=%b exp=%b", i, mie_global, m_mie); end
            n_tests++; if (mtvec_o !== m_mtvec || mepc_o !== m_mepc) begin n_fail++; $display("FAIL rand_vec i=%0d mtvec=%h/%h mepc=%h/%h", i, mtvec_o, m_mtvec, mepc_o, m_mepc); end
            tick();
        end
        retire = 0; trap_valid = 0; mret = 0;
    endtask

    task automatic test_async_reset();
        setop(RSI, 12'h300, 5'd8, 32'h0);
        tick();
        setop(RW, 12'h340, 5'd1, 32'hA5A5_A5A5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++; if (rd !== 32'h0 || illegal !== 1'b0) begin n_fail++; $display("FAIL areset_scratch rd=%h ill=%b exp 0/0", rd, illegal); end
        n_tests++; if (mie_global !== 1'b0) begin n_fail++; $display("FAIL areset_mie got=%b exp=0", mie_global); end
        setop(RS, 12'h305, 5'd0, 32'h0);
        #1;
        n_tests++; if (rd !== MTV) begin n_fail++; $display("FAIL areset_mtvec rd=%h exp=%h", rd, MTV); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        setop(RS, 12'hC00, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL areset_cycle rd=%h exp=1", rd); end
        tick();
        setop(RS, 12'h340, 5'd0, 32'h0);
        @(negedge clk);
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL areset_nowrite rd=%h exp=0", rd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_mstatus();
        test_readonly();
        test_counters();
        test_trap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR block for the single-cycle/multi-cycle RISC-V core; successor to the flat 4096-entry CSR array.
- Implements only architected M-mode CSRs, plus 64-bit cycle/instret counters, read-only decode, illegal-access flagging, rd/rs1=x0 side-effect suppression, and hardware trap-entry/mret updates.
- Sits beside the register file; driven by the main decoder (CSRControl) and the trap/retire logic.

Parameters:
- XLEN, 32, data width of CSRs and the wd/rd buses.
- CNT_W, 64, width of mcycle/minstret (must be greater than or equal to XLEN and at most 2*XLEN).
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- CSRControl  in  4  [3]=CSR instruction valid/write enable, [2:0]=funct3.
- instr  in  32  current instruction; csr=[31:20], rs1/zimm=[19:15], rd=[11:7].
- wd  in  XLEN  rs1 value.
- rd  out  XLEN  old CSR value (combinational).
- illegal  out  1  illegal CSR access this cycle (combinational).
- retire  in  1  an instruction retires this cycle.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  XLEN  mcause value.
- trap_pc  in  XLEN  faulting PC, goes to mepc.
- trap_val  in  XLEN  goes to mtval.
- mret  in  1  mret executes this cycle.
- mtvec_o  out  XLEN  current mtvec.
- mepc_o  out  XLEN  current mepc.
- mie_global  out  1  mstatus.MIE.

Behaviour:
- Implemented addresses: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (read-only, reads 0), mcycle B00/mcycleh B80, minstret B02/minstreth B82, cycle C00/C80, instret C02/C82 (read-only shadows), mhartid F14 (read-only).
- Any other address with CSRControl[3]=1: illegal=1, rd=0, no state change.
- Read path is combinational from the current state; rd returns the pre-write value. When rd field=x0, rd is still driven, but rd=x0 has no effect on the write.
- Write data by funct3: 001=wd, 010=old|wd, 011=old&~wd, 101=zimm, 110=old|zimm, 111=old&~zimm; 000/100: illegal=1, no write. zimm is zero-extended to XLEN.
- Set/clear variants (010,011,110,111) with rs1 field=0 perform no write and are never illegal for read-only addresses.
- Write to a read-only address (csr[11:10]=2'b11) with a real write intent: illegal=1, no write.
- Field masking:
  - mstatus writable bits are MIE[3], MPIE[7] only; others read 0.
  - MPP[12:11] reads 2'b11 constant.
  - mtvec[1:0] is forced 0 (direct mode).
  - mepc[1:0] is forced 0.
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments when retire=1.
  - Increment carries across the 64-bit value; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A CSR write to a counter half replaces that half and suppresses that counter's increment in the same cycle.
- Trap entry (trap_valid=1), at the next edge:
  - mepc=trap_pc&~3, mcause=trap_cause, mtval=trap_val, MPIE=MIE, MIE=0.
  - Trap has priority over a simultaneous CSR write (CSR write dropped) and over mret.
- mret: MIE=MPIE, MPIE=1.
- Reset (async, any time, including mid-write):
  - all CSRs are 0 except mtvec=MTVEC_RESET.
  - rd, illegal and mie_global are combinational and follow the reset state (mie_global=0).
- Latency: read 0 cycles; write, counter and trap updates visible the cycle after the edge.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - funct3 enum (CSRRW..CSRRCI);
  - mstatus bit-index constants;
  - writable-mask constants.
- Sub-module csr_counter (CNT_W, inc, wr_lo, wr_hi, wdata) is instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then read 305 -> rd=MTVEC_RESET; read 300 -> rd=0x1800; mie_global=0.
- csrrw 340 with wd=0xDEADBEEF -> rd=0 this cycle; next read of 340 -> 0xDEADBEEF.
- csrrs 300 with rs1=x0 -> no write; csrrsi 300 with zimm=8 -> mie_global=1 next cycle.
- csrrw to C00 -> illegal=1, counter unaffected; csrrs C00 with rs1=x0 -> illegal=0, rd=cycle count.
- Preload mcycle=0x0000_0000_FFFF_FFFF via B00/B80; one cycle later B80 reads 1 and B00 reads 0; a write to B00 in the same cycle as the wrap takes the written value.
- With MIE=1, trap_valid with trap_pc=0x103, cause=0xB plus a simultaneous csrrw 342 -> mepc=0x100, mcause=0xB, MIE=0, MPIE=1; then mret -> MIE=1.
